vga_stream_formatter: RTL and testbench

Parametrised pixel-stream formatter between a grayscale pixel producer and the VGA streaming sink. It accepts an IN_WIDTH-bit grayscale Avalon-ST stream and emits a 3×OUT_CH_WIDTH-bit RGB Avalon-ST stream. It applies a selectable colour mode and regenerates start/end-of-packet markers from internal frame counters. A small output FIFO absorbs sink back-pressure. Framing errors are detected and flagged, and a frame counter is provided.

---
 rtl/vga_stream_formatter.sv | 177 +++++++++++++++++
 tb/tb_vga_stream_formatter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_formatter.sv
// Grayscale Avalon-ST to RGB Avalon-ST formatter. It applies a colour mode,
// regenerates frame markers from position counters, and buffers output in a small FIFO.
module vga_stream_formatter #(
    parameter int IN_WIDTH     = 8,
    parameter int OUT_CH_WIDTH = 10,
    parameter int FRAME_W      = 640,
    parameter int FRAME_H      = 480,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic [IN_WIDTH-1:0]       threshold,
    input  logic                      err_clear,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    input  logic                      in_sop,
    input  logic                      in_eop,
    output logic                      in_ready,
    output logic [3*OUT_CH_WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      out_sop,
    output logic                      out_eop,
    input  logic                      out_ready,
    output logic [15:0]               frame_count,
    output logic [1:0]                err_flags
);

    localparam int OUT_W = 3 * OUT_CH_WIDTH;
    localparam int EXT   = OUT_CH_WIDTH - IN_WIDTH;
    localparam int XW    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int YW    = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sop;
        logic             eop;
    } pix_t;

    typedef enum logic {WAIT_SOP, ACTIVE} state_t;

    state_t              state_q, state_n;
    logic [XW-1:0]       x_q, x_n, pos_x;
    logic [YW-1:0]       y_q, y_n, pos_y;
    logic [1:0]          mode_q, mode_n, eff_mode;
    logic                ready_q;
    logic                accept, restart, wr_en, at_first, at_last, frame_done;
    logic [1:0]          err_new;
    logic [IN_WIDTH-1:0] g_n;
    logic [OUT_CH_WIDTH-1:0] rep_g, rep_n;
    logic [OUT_W-1:0]    pix_rgb;
    pix_t                wr_pix;

    pix_t                mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                full, pop;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign in_ready = ready_q && !full;
    assign accept   = in_valid && in_ready;
    assign restart  = accept && in_sop;
    assign wr_en    = accept && (in_sop || state_q == ACTIVE);

    // An SOP pixel is always placed at (0,0), whatever the counters say.
    assign pos_x    = restart ? '0 : x_q;
    assign pos_y    = restart ? '0 : y_q;
    assign at_first = (pos_x == '0) && (pos_y == '0);
    assign at_last  = (pos_x == X_LAST) && (pos_y == Y_LAST);
    assign eff_mode = restart ? mode : mode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_SOP;
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= '0;
            ready_q     <= 1'b0;
            frame_count <= '0;
            err_flags   <= '0;
        end else begin
            state_q   <= state_n;
            x_q       <= x_n;
            y_q       <= y_n;
            mode_q    <= mode_n;
            ready_q   <= 1'b1;
            if (frame_done) frame_count <= frame_count + 1'b1;
            err_flags <= (err_clear ? 2'b00 : err_flags) | err_new;
        end
    end

    always_comb begin
        state_n    = state_q;
        x_n        = x_q;
        y_n        = y_q;
        mode_n     = mode_q;
        err_new    = '0;
        frame_done = 1'b0;
        if (restart) begin
            mode_n = mode;
            if (state_q == ACTIVE && !((x_q == '0) && (y_q == '0))) err_new[0] = 1'b1;
        end
        if (wr_en) begin
            if (in_eop != at_last) err_new[1] = 1'b1;
            if (at_last) begin
                state_n    = WAIT_SOP;
                x_n        = '0;
                y_n        = '0;
                frame_done = 1'b1;
            end else begin
                state_n = ACTIVE;
                if (pos_x == X_LAST) begin
                    x_n = '0;
                    y_n = pos_y + 1'b1;
                end else begin
                    x_n = pos_x + 1'b1;
                    y_n = pos_y;
                end
            end
        end
    end

    // Widening fills the low bits with the top bits of the sample so full scale maps to full scale.
    assign g_n = ~in_data;
    generate
        if (EXT == 0) begin : g_rep_eq
            assign rep_g = in_data;
            assign rep_n = g_n;
        end else begin : g_rep_ext
            assign rep_g = {in_data, in_data[IN_WIDTH-1 -: EXT]};
            assign rep_n = {g_n, g_n[IN_WIDTH-1 -: EXT]};
        end
    endgenerate

    always_comb begin
        pix_rgb = '0;
        case (eff_mode)
            2'd0:    pix_rgb = {rep_g, rep_g, rep_g};
            2'd1:    pix_rgb = {OUT_W{in_data >= threshold}};
            2'd2:    pix_rgb = {rep_n, rep_n, rep_n};
            default: pix_rgb = {rep_g, {OUT_CH_WIDTH{1'b0}}, rep_n};
        endcase
    end

    assign wr_pix = '{data: pix_rgb, sop: at_first, eop: at_last};

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr].data;
    assign out_sop   = mem[rd_ptr].sop;
    assign out_eop   = mem[rd_ptr].eop;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_pix;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_stream_formatter.sv
// Bench for vga_stream_formatter on a 4x2 frame; a pixel-index reference model
// predicts the output stream, frame count and error flags.
module tb_vga_stream_formatter;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic        err_clear;
    logic [7:0]  in_data;
    logic        in_valid, in_sop, in_eop, in_ready;
    logic [29:0] out_data;
    logic        out_valid, out_sop, out_eop, out_ready;
    logic [15:0] frame_count;
    logic [1:0]  err_flags;

    typedef struct packed {
        logic [29:0] d;
        logic        s;
        logic        e;
    } ent_t;

    ent_t got_q[$];
    ent_t exp_q[$];
    int   m_idx, m_fc;
    logic [1:0] m_mode, m_err, m_new;
    logic m_wr, m_last;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   rnd_rdy = 0;

    vga_stream_formatter #(
        .IN_WIDTH(8), .OUT_CH_WIDTH(10), .FRAME_W(W), .FRAME_H(H), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .threshold(threshold), .err_clear(err_clear),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
        .out_eop(out_eop), .out_ready(out_ready), .frame_count(frame_count), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    // 8-bit to 10-bit widening: shift up, fill with the two top bits.
    function automatic logic [9:0] rep(input logic [7:0] v);
        return 10'(v) * 10'd4 + 10'(v >> 6);
    endfunction

    function automatic logic [29:0] colour(input logic [1:0] md, input logic [7:0] g, input logic [7:0] th);
        logic [7:0] inv;
        inv = 8'(255 - int'(g));
        case (md)
            2'd0:    return {rep(g), rep(g), rep(g)};
            2'd1:    return (g >= th) ? {3{10'h3FF}} : 30'h0;
            2'd2:    return {rep(inv), rep(inv), rep(inv)};
            default: return {rep(g), 10'h000, rep(inv)};
        endcase
    endfunction

    // Reference model and output capture, evaluated mid-cycle when everything is stable.
    always @(negedge clk) begin
        if (reset) begin
            got_q.delete();
            exp_q.delete();
            m_idx  = -1;
            m_fc   = 0;
            m_err  = 2'b00;
            m_mode = 2'b00;
        end else begin
            m_new = 2'b00;
            if (out_valid && out_ready) got_q.push_back({out_data, out_sop, out_eop});
            if (in_valid && in_ready) begin
                m_wr = 1'b0;
                if (in_sop) begin
                    if (m_idx > 0) m_new[0] = 1'b1;
                    m_idx  = 0;
                    m_mode = mode;
                    m_wr   = 1'b1;
                end else if (m_idx >= 0) begin
                    m_wr = 1'b1;
                end
                if (m_wr) begin
                    m_last = (m_idx == N - 1);
                    if (in_eop != m_last) m_new[1] = 1'b1;
                    exp_q.push_back({colour(m_mode, in_data, threshold), m_idx == 0, m_last});
                    if (m_last) begin
                        m_fc  = (m_fc + 1) % 65536;
                        m_idx = -1;
                    end else begin
                        m_idx++;
                    end
                end
            end
            m_err = (err_clear ? 2'b00 : m_err) | m_new;
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        idle();
        in_data   = 8'h00;
        out_ready = 1'b1;
        rnd_rdy   = 0;
        err_clear = 1'b0;
        mode      = 2'd0;
        threshold = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Holds the pixel until accepted; returns one tick after the accepting edge.
    task automatic send(input logic [7:0] g, input logic s, input logic e);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = g;
        in_sop   = s;
        in_eop   = e;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        n_chk++;
        if (!done) $display("FAIL send_accept: in_ready stayed %b for 200 cycles, required 1", in_ready);
        else n_pass++;
    endtask

    task automatic drain();
        bit empty = 0;
        idle();
        rnd_rdy   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !empty; i++) begin
            @(negedge clk);
            empty = !out_valid;
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (!empty) $display("FAIL drain: out_valid=%b after 100 cycles, required 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        out_ready = 1'b1;
        err_clear = 1'b0;
        mode = 2'd0;
        threshold = 8'h00;
        in_data = 8'h00;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready); else n_pass++;
        n_chk++; if ({out_valid, out_sop, out_eop} !== 3'b000) $display("FAIL reset_out_ctrl: got %b required 000", {out_valid, out_sop, out_eop}); else n_pass++;
        n_chk++; if (out_data !== 30'h0) $display("FAIL reset_out_data: got %h required 0", out_data); else n_pass++;
        n_chk++; if (frame_count !== 16'd0) $display("FAIL reset_frame_count: got %0d required 0", frame_count); else n_pass++;
        n_chk++; if (err_flags !== 2'b00) $display("FAIL reset_err_flags: got %b required 00", err_flags); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_ready_after: got %b required 1", in_ready); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_gray_frame();
        do_reset();
        send(8'h80, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        n_chk++; if ({out_valid, out_sop} !== 2'b11) $display("FAIL gray_latency: got valid,sop=%b required 11", {out_valid, out_sop}); else n_pass++;
        @(posedge clk);
        #1;
        for (int k = 1; k < N; k++) send(8'h80, 1'b0, k == N - 1);
        drain();
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL gray_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) $display("FAIL gray_px%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
            else n_pass++;
        end
        if (got_q.size() == N) begin
            n_chk++; if (got_q[0].d !== {3{10'h202}}) $display("FAIL gray_value: got %h required %h", got_q[0].d, {3{10'h202}}); else n_pass++;
            n_chk++; if ({got_q[0].s, got_q[7].e} !== 2'b11) $display("FAIL gray_markers: got sop0,eop7=%b required 11", {got_q[0].s, got_q[7].e}); else n_pass++;
        end
        n_chk++; if (frame_count !== 16'd1) $display("FAIL gray_frame_count: got %0d required 1", frame_count); else n_pass++;
        n_chk++; if (err_flags !== 2'b00) $display("FAIL gray_err: got %b required 00", err_flags); else n_pass++;
    endtask

    task automatic test_no_sop();
        do_reset();
        for (int k = 0; k < 3; k++) send(8'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < N; k++) send(8'($urandom), k == 0, k == N - 1);
        drain();
        n_chk++; if (got_q.size() != N) $display("FAIL nosop_count: got %0d outputs, required %0d", got_q.size(), N); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) $display("FAIL nosop_px%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
            else n_pass++;
        end
        if (got_q.size() > 0) begin
            n_chk++; if (got_q[0].s !== 1'b1) $display("FAIL nosop_first_sop: got %b required 1", got_q[0].s); else n_pass++;
        end
    endtask

    task automatic test_early_sop();
        do_reset();
        send(8'h10, 1'b1, 1'b0);
        send(8'h20, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) send(8'(8'h30 + k), k == 0, k == N - 1);
        drain();
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL early_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) $display("FAIL early_px%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
            else n_pass++;
        end
        if (got_q.size() == N + 2) begin
            n_chk++; if ({got_q[1].e, got_q[2].s} !== 2'b01) $display("FAIL early_markers: got eop1,sop2=%b required 01", {got_q[1].e, got_q[2].s}); else n_pass++;
        end
        n_chk++; if (err_flags !== 2'b01) $display("FAIL early_err: got %b required 01", err_flags); else n_pass++;
        n_chk++; if (frame_count !== 16'd1) $display("FAIL early_frame_count: got %0d required 1", frame_count); else n_pass++;
    endtask

    task automatic test_eop_mismatch();
        do_reset();
        for (int k = 0; k < N; k++) send(8'($urandom), k == 0, k == 4);
        drain();
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) $display("FAIL eopmis_px%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
            else n_pass++;
        end
        if (got_q.size() == N) begin
            n_chk++; if ({got_q[4].e, got_q[7].e} !== 2'b01) $display("FAIL eopmis_markers: got eop4,eop7=%b required 01", {got_q[4].e, got_q[7].e}); else n_pass++;
        end
        n_chk++; if (err_flags !== 2'b10) $display("FAIL eopmis_err: got %b required 10", err_flags); else n_pass++;
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        @(negedge clk);
        n_chk++; if (err_flags !== 2'b00) $display("FAIL eopmis_clear: got %b required 00", err_flags); else n_pass++;
        @(posedge clk);
        #1;
        // Clear and a fresh error on the same edge: the error must survive.
        err_clear = 1'b1;
        send(8'h55, 1'b1, 1'b1);
        err_clear = 1'b0;
        drain();
        n_chk++; if (err_flags !== m_err) $display("FAIL eopmis_clear_race: got %b expected %b", err_flags, m_err); else n_pass++;
        n_chk++; if (err_flags !== 2'b10) $display("FAIL eopmis_new_wins: got %b required 10", err_flags); else n_pass++;
    endtask

    task automatic test_modes();
        do_reset();
        threshold = 8'h40;
        mode = 2'd1;
        for (int k = 0; k < N; k++) send((k % 2 == 0) ? 8'h3F : 8'h40, k == 0, k == N - 1);
        mode = 2'd2;
        for (int k = 0; k < N; k++) send(8'h00, k == 0, k == N - 1);
        mode = 2'd3;
        for (int k = 0; k < N; k++) begin
            if (k == 2) mode = 2'd0;
            send(8'hFF, k == 0, k == N - 1);
        end
        for (int k = 0; k < N; k++) send(8'hFF, k == 0, k == N - 1);
        drain();
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL modes_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) $display("FAIL modes_px%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
            else n_pass++;
        end
        if (got_q.size() == 4 * N) begin
            n_chk++; if (got_q[0].d !== 30'h0) $display("FAIL mode1_below: got %h required 0", got_q[0].d); else n_pass++;
            n_chk++; if (got_q[1].d !== {3{10'h3FF}}) $display("FAIL mode1_equal: got %h required %h", got_q[1].d, {3{10'h3FF}}); else n_pass++;
            n_chk++; if (got_q[8].d !== {3{10'h3FF}}) $display("FAIL mode2_zero: got %h required %h", got_q[8].d, {3{10'h3FF}}); else n_pass++;
            n_chk++; if (got_q[20].d !== {10'h3FF, 20'h0}) $display("FAIL mode3_hold: got %h required %h", got_q[20].d, {10'h3FF, 20'h0}); else n_pass++;
            n_chk++; if (got_q[24].d !== {3{10'h3FF}}) $display("FAIL mode_next_sop: got %h required %h", got_q[24].d, {3{10'h3FF}}); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int acc = 0;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(k * 17 + 3);
            in_sop   = (k == 0);
            in_eop   = 1'b0;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            k = acc;
        end
        idle();
        @(negedge clk);
        n_chk++; if (acc != 4) $display("FAIL bp_accepts: got %0d accepts required 4", acc); else n_pass++;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", in_ready); else n_pass++;
        n_chk++; if ({out_valid, out_sop, out_data} !== {2'b11, colour(2'd0, 8'd3, 8'd0)}) $display("FAIL bp_hold: got v,s,d=%b%b %h required 11 %h", out_valid, out_sop, out_data, colour(2'd0, 8'd3, 8'd0)); else n_pass++;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int j = k; j < N; j++) send(8'(j * 17 + 3), 1'b0, j == N - 1);
        drain();
        n_chk++; if (got_q.size() != N) $display("FAIL bp_count: got %0d outputs, required %0d", got_q.size(), N); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_px%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < N; k++) send(8'($urandom), k == 0, k == N - 1);
        drain();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(8'($urandom), k == 0, 1'b0);
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_chk++; if ({out_valid, in_ready} !== 2'b00) $display("FAIL midrst_flow: got valid,ready=%b required 00", {out_valid, in_ready}); else n_pass++;
        n_chk++; if (frame_count !== 16'd0) $display("FAIL midrst_frame_count: got %0d required 0", frame_count); else n_pass++;
        do_reset();
        for (int k = 0; k < N; k++) send(8'($urandom), k == 0, k == N - 1);
        drain();
        n_chk++; if (got_q.size() != N) $display("FAIL midrst_count: got %0d outputs, required %0d", got_q.size(), N); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) $display("FAIL midrst_px%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
            else n_pass++;
        end
        n_chk++; if (frame_count !== 16'd1) $display("FAIL midrst_frames: got %0d required 1", frame_count); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        rnd_rdy = 1;
        for (int k = 0; k < 400; k++) begin
            int p = k % N;
            logic s, e;
            s = (p == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 40) == 0);
            e = (p == N - 1) ^ ($urandom_range(0, 30) == 0);
            mode      = 2'($urandom);
            threshold = 8'($urandom);
            err_clear = ($urandom_range(0, 30) == 0);
            send(8'($urandom), s, e);
            err_clear = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        drain();
        n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rand_px%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b", i, got_q[i].d, got_q[i].s, got_q[i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
            else n_pass++;
        end
        n_chk++; if (frame_count !== 16'(m_fc)) $display("FAIL rand_frame_count: got %0d expected %0d", frame_count, m_fc); else n_pass++;
        n_chk++; if (err_flags !== m_err) $display("FAIL rand_err: got %b expected %b", err_flags, m_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_gray_frame();
        test_no_sop();
        test_early_sop();
        test_eop_mismatch();
        test_modes();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
